// File: rtl/seg_display_scanner.sv
// seg_display_scanner: double-buffered, blinking, time-multiplexed 7-segment display driver
module seg_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_DIV = 64,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    hex_mode,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic POL = ACTIVE_LOW != 0;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] frame_cnt;
  logic blink_phase;
  logic [4*NUM_DIGITS-1:0] p_dig, a_dig;
  logic [NUM_DIGITS-1:0] p_dp, a_dp, p_blank, a_blank, p_blink, a_blink;
  logic [6:0] seg_r, seg_d;
  logic dp_r, tick_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic scan_end, wrap, pre_wrap, blink_end, dark;
  logic [3:0] nib;
  assign scan_end = scan_cnt == SW'(SCAN_DIV - 1);
  assign wrap = scan_end && idx == IW'(NUM_DIGITS - 1);
  // frame_tick is registered one cycle early so it is high during the wrap cycle itself
  assign pre_wrap = scan_cnt == SW'(SCAN_DIV - 2) && idx == IW'(NUM_DIGITS - 1);
  assign blink_end = frame_cnt == BW'(BLINK_DIV - 1);
  assign nib = a_dig[4*idx +: 4];
  assign dark = a_blank[idx] | (a_blink[idx] & blink_phase);
  always_comb begin
    case (nib)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'ha: seg_d = hex_mode ? 7'b1110111 : 7'b0000001;
      4'hb: seg_d = hex_mode ? 7'b0011111 : 7'b0000001;
      4'hc: seg_d = hex_mode ? 7'b1001110 : 7'b0000001;
      4'hd: seg_d = hex_mode ? 7'b0111101 : 7'b0000001;
      4'he: seg_d = hex_mode ? 7'b1001111 : 7'b0000001;
      default: seg_d = hex_mode ? 7'b1000111 : 7'b0000001;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      p_dig <= '0;
      p_dp <= '0;
      p_blank <= '1;
      p_blink <= '0;
      a_dig <= '0;
      a_dp <= '0;
      a_blank <= '1;
      a_blink <= '0;
      seg_r <= 7'b0000001;
      dp_r <= 1'b0;
      sel_r <= '0;
      tick_r <= 1'b0;
    end else begin
      scan_cnt <= scan_end ? '0 : scan_cnt + 1'b1;
      if (scan_end) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) frame_cnt <= blink_end ? '0 : frame_cnt + 1'b1;
      if (wrap && blink_end) blink_phase <= ~blink_phase;
      if (load) begin
        p_dig <= digits_in;
        p_dp <= dp_in;
        p_blank <= blank_in;
        p_blink <= blink_in;
      end
      if (wrap) begin
        a_dig <= load ? digits_in : p_dig;
        a_dp <= load ? dp_in : p_dp;
        a_blank <= load ? blank_in : p_blank;
        a_blink <= load ? blink_in : p_blink;
      end
      seg_r <= dark ? 7'b0000000 : seg_d;
      dp_r <= ~dark & a_dp[idx];
      sel_r <= NUM_DIGITS'(1) << idx;
      tick_r <= pre_wrap;
    end
  end
  assign seg_out = POL ? ~seg_r : seg_r;
  assign dp_out = POL ? ~dp_r : dp_r;
  assign digit_sel = POL ? ~sel_r : sel_r;
  assign frame_tick = tick_r;
endmodule
